// File: rtl/clock_div_pkg.sv
// -----------------------------------------------------------------------------
// clock_div_pkg
//   Shared definitions for the multi-channel clock divider.
//   - DIV_MIN      : smallest legal divide ratio (one high and one low cycle).
//   - STATE_W      : width of the per-channel state encoding.
//   - ch_state_t   : per-channel FSM state (IDLE / HIGH / LOW).
//   - hi_len_of()  : high-phase length for a total period N.
//   - lo_len_of()  : low-phase length for a total period N.
// -----------------------------------------------------------------------------
package clock_div_pkg;

    localparam int unsigned DIV_MIN = 2;
    localparam int          STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } ch_state_t;

    // The high phase takes the rounded-up half, so odd ratios yield a high
    // phase one cycle longer than the low phase. Both helpers operate on a
    // fixed 32-bit value so any counter width up to 32 can share them.
    function automatic logic [31:0] hi_len_of(input logic [31:0] n);
        return n - (n >> 1);
    endfunction

    function automatic logic [31:0] lo_len_of(input logic [31:0] n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/clock_div_channel.sv
// -----------------------------------------------------------------------------
// clock_div_channel
//   One divided-clock channel: IDLE/HIGH/LOW FSM, phase counter, active and
//   pending divide ratio, and one-cycle rise/fall strobes.
//
// Ports:
//   clk        in   board clock
//   resetn     in   asynchronous active-low reset
//   en         in   run enable (level)
//   sync_start in   restart in phase (only acts when en=1)
//   wr         in   accepted ratio write for this channel (already validated)
//   wr_div     in   ratio carried by wr
//   clk_out    out  divided clock (registered)
//   rise_tick  out  first cycle of clk_out=1 after 0
//   fall_tick  out  first cycle of clk_out=0 after 1
//   pend       out  a written ratio is waiting for the next period boundary
//   state      out  current FSM state (debug)
// -----------------------------------------------------------------------------
module clock_div_channel
    import clock_div_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             sync_start,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             clk_out,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic             pend,
    output ch_state_t        state
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_pend;

    ch_state_t        state_n;
    logic [CNT_W-1:0] cnt_n;
    logic             clk_n;
    logic             rise_n;
    logic             fall_n;
    logic             apply;

    // Terminal counts are compared at 32 bits so no bit of the helper
    // results is left dangling.
    logic [31:0] hi_last;
    logic [31:0] lo_last;
    logic [31:0] cnt_ext;

    assign hi_last = hi_len_of(32'(div_act)) - 32'd1;
    assign lo_last = lo_len_of(32'(div_act)) - 32'd1;
    assign cnt_ext = 32'(cnt);

    // Next-state / output decode. A HIGH entry is the only place where a
    // pending ratio may be applied, which keeps every period whole.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        clk_n   = clk_out;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        apply   = 1'b0;

        if (sync_start && en) begin
            state_n = ST_HIGH;
            cnt_n   = '0;
            clk_n   = 1'b1;
            rise_n  = !clk_out;
            apply   = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    clk_n = 1'b0;
                    if (en) begin
                        state_n = ST_HIGH;
                        cnt_n   = '0;
                        clk_n   = 1'b1;
                        rise_n  = 1'b1;
                        apply   = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (cnt_ext == hi_last) begin
                        state_n = ST_LOW;
                        cnt_n   = '0;
                        clk_n   = 1'b0;
                        fall_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                ST_LOW: begin
                    // en is only consulted at the end of the low phase, so
                    // a drop mid-period still finishes the period and a
                    // re-raise before then cancels the stop.
                    if (cnt_ext == lo_last) begin
                        cnt_n = '0;
                        if (en) begin
                            state_n = ST_HIGH;
                            clk_n   = 1'b1;
                            rise_n  = 1'b1;
                            apply   = 1'b1;
                        end else begin
                            state_n = ST_IDLE;
                            clk_n   = 1'b0;
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    clk_n   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            clk_out   <= 1'b0;
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            clk_out   <= clk_n;
            rise_tick <= rise_n;
            fall_tick <= fall_n;
        end
    end

    // Ratio bookkeeping. A boundary consumes the value that was pending
    // before this edge; a write arriving on the same edge is stored for the
    // following boundary and keeps pend set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_act  <= CNT_W'(DEFAULT_DIV);
            div_pend <= CNT_W'(DEFAULT_DIV);
            pend     <= 1'b0;
        end else begin
            if (apply && pend) begin
                div_act <= div_pend;
            end
            if (wr) begin
                div_pend <= wr_div;
                pend     <= 1'b1;
            end else if (apply) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clock_div_multi.sv
// -----------------------------------------------------------------------------
// clock_div_multi
//   NUM_CH independent glitch-free divided clocks from clk_50M, each with a
//   runtime-programmable ratio and run enable, plus rise/fall strobes and a
//   global in-phase restart.
//
// Ports:
//   clk_50M    in   board clock (single domain)
//   resetn     in   asynchronous active-low reset
//   ch_en      in   per-channel run enable (level)
//   sync_start in   one-cycle pulse: restart all enabled channels in phase
//   cfg_wr     in   ratio write strobe
//   cfg_ch     in   channel targeted by cfg_wr
//   cfg_div    in   new total period N in clk_50M cycles
//   cfg_err    out  one-cycle pulse: write rejected
//   cfg_pend   out  per-channel: accepted ratio not yet applied
//   clk_out    out  divided clocks (registered)
//   rise_tick  out  first cycle of clk_out[i]=1 after 0
//   fall_tick  out  first cycle of clk_out[i]=0 after 1
//   ch_state   out  per-channel FSM state (debug)
//
// Config handshake: cfg_wr is a one-cycle valid with no ready; every strobe is
// resolved on the following cycle as either cfg_pend[cfg_ch]=1 (accepted) or
// cfg_err=1 (rejected: cfg_div below DIV_MIN or cfg_ch out of range).
// -----------------------------------------------------------------------------
module clock_div_multi
    import clock_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 2,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                            clk_50M,
    input  logic                            resetn,
    input  logic [NUM_CH-1:0]               ch_en,
    input  logic                            sync_start,
    input  logic                            cfg_wr,
    input  logic [CH_W-1:0]                 cfg_ch,
    input  logic [CNT_W-1:0]                cfg_div,
    output logic                            cfg_err,
    output logic [NUM_CH-1:0]               cfg_pend,
    output logic [NUM_CH-1:0]               clk_out,
    output logic [NUM_CH-1:0]               rise_tick,
    output logic [NUM_CH-1:0]               fall_tick,
    output logic [NUM_CH-1:0][STATE_W-1:0]  ch_state
);

    logic              ch_ok;
    logic              div_ok;
    logic              wr_ok;
    logic [NUM_CH-1:0] wr_sel;
    ch_state_t         st [NUM_CH];

    // cfg_ch may be wider than needed to address NUM_CH channels, so the
    // range check is real logic whenever NUM_CH is not a power of two or
    // CH_W is widened.
    assign ch_ok  = 32'(cfg_ch) < 32'(NUM_CH);
    assign div_ok = cfg_div >= CNT_W'(DIV_MIN);
    assign wr_ok  = cfg_wr && ch_ok && div_ok;

    always_ff @(posedge clk_50M or negedge resetn) begin
        if (!resetn) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_wr && !wr_ok;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_sel[i] = wr_ok && (32'(cfg_ch) == 32'(i));

        clock_div_channel #(
            .CNT_W      (CNT_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .clk       (clk_50M),
            .resetn    (resetn),
            .en        (ch_en[i]),
            .sync_start(sync_start),
            .wr        (wr_sel[i]),
            .wr_div    (cfg_div),
            .clk_out   (clk_out[i]),
            .rise_tick (rise_tick[i]),
            .fall_tick (fall_tick[i]),
            .pend      (cfg_pend[i]),
            .state     (st[i])
        );

        assign ch_state[i] = st[i];
    end

endmodule
